// File: rtl/count_wrap_monitor.sv
// -----------------------------------------------------------------------------
// count_wrap_monitor
//
// Watches the 4-bit value of an upstream ripple carry counter and checks that
// it advances by exactly +1 (mod 16) on every clock. It counts 15->0 wraps and
// raises a sticky fault when the counter jumps or stalls for too long.
//
// All outputs are registered: each one reflects the q sampled on the previous
// rising edge of clk.
//
// Parameters
//   WRAP_W     width of the saturating wrap counter
//   STALL_MAX  number of consecutive repeated samples tolerated; the next
//              repeat is a stall fault
//
// Ports
//   clk         sole clock, all state changes on posedge
//   reset       synchronous, active-high reset; dominates everything
//   q           counter value under observation
//   clear       synchronous request to drop the fault/lock and re-acquire
//   locked      high while a valid +1 sequence is being tracked
//   wrap_pulse  one-cycle pulse for every 15->0 wrap seen
//   wrap_count  number of wraps seen, saturating at all-ones
//   step_error  one-cycle pulse on entry into the fault state
//   fault       sticky fault flag
//   fault_code  00 none, 01 jump, 10 stall (11 never produced)
// -----------------------------------------------------------------------------
module count_wrap_monitor #(
  parameter int WRAP_W    = 8,
  parameter int STALL_MAX = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        q,
  input  logic              clear,
  output logic              locked,
  output logic              wrap_pulse,
  output logic [WRAP_W-1:0] wrap_count,
  output logic              step_error,
  output logic              fault,
  output logic [1:0]        fault_code
);

  // The stall counter must be able to hold the value STALL_MAX itself,
  // because that is the value it is compared against.
  localparam int STALL_W = (STALL_MAX < 1) ? 1 : $clog2(STALL_MAX + 1);
  localparam logic [STALL_W-1:0] STALL_LIMIT = STALL_W'(STALL_MAX);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    FAULT = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    FC_NONE  = 2'b00,
    FC_JUMP  = 2'b01,
    FC_STALL = 2'b10
  } fault_code_t;

  // ---------------------------------------------------------------------------
  // State and next-state signals
  // ---------------------------------------------------------------------------
  state_t              state,        state_d;
  logic [3:0]          prev_q,       prev_q_d;
  logic [STALL_W-1:0]  stall_cnt,    stall_cnt_d;
  fault_code_t         fault_code_r, fault_code_d;
  logic                locked_d;
  logic                wrap_pulse_d;
  logic                step_error_d;
  logic                fault_d;
  logic [WRAP_W-1:0]   wrap_count_d;

  // ---------------------------------------------------------------------------
  // Step classification against the previously captured sample
  // ---------------------------------------------------------------------------
  logic [3:0] q_next_expected;
  logic       step_ok;
  logic       step_same;
  logic       wrap_seen;
  logic       wrap_full;

  // The 4-bit add wraps 15 -> 0 on its own, which is exactly the mod-16 rule.
  assign q_next_expected = prev_q + 4'd1;
  assign step_ok         = (q == q_next_expected);
  assign step_same       = (q == prev_q);
  // Only meaningful together with step_ok, which then implies q == 0.
  assign wrap_seen       = (prev_q == 4'hF);
  assign wrap_full       = &wrap_count;

  // ---------------------------------------------------------------------------
  // Next-state and registered-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written below gets a default first, so no path
    // through the case/if tree can leave one unassigned and infer a latch.
    state_d      = state;
    prev_q_d     = prev_q;
    stall_cnt_d  = stall_cnt;
    fault_code_d = fault_code_r;
    locked_d     = locked;
    fault_d      = fault;
    wrap_count_d = wrap_count;
    wrap_pulse_d = 1'b0;
    step_error_d = 1'b0;

    unique case (state)
      IDLE: begin
        // Capture a reference sample; nothing can be checked yet. A clear
        // arriving here has nothing extra to undo.
        prev_q_d    = q;
        stall_cnt_d = '0;
        locked_d    = 1'b0;
        state_d     = TRACK;
      end

      TRACK: begin
        prev_q_d = q;
        if (clear) begin
          // Clear wins over this cycle's step check.
          state_d      = IDLE;
          stall_cnt_d  = '0;
          locked_d     = 1'b0;
          fault_d      = 1'b0;
          fault_code_d = FC_NONE;
        end else if (step_ok) begin
          stall_cnt_d = '0;
          locked_d    = 1'b1;
          if (wrap_seen) begin
            // A saturated counter still reports every wrap on the pulse.
            wrap_pulse_d = 1'b1;
            if (!wrap_full) begin
              wrap_count_d = wrap_count + WRAP_W'(1);
            end
          end
        end else if (step_same) begin
          if (stall_cnt == STALL_LIMIT) begin
            state_d      = FAULT;
            step_error_d = 1'b1;
            fault_d      = 1'b1;
            locked_d     = 1'b0;
            fault_code_d = FC_STALL;
          end else begin
            // Tolerated repeat: lock indication is left as it was.
            stall_cnt_d = stall_cnt + STALL_W'(1);
          end
        end else begin
          state_d      = FAULT;
          step_error_d = 1'b1;
          fault_d      = 1'b1;
          locked_d     = 1'b0;
          fault_code_d = FC_JUMP;
        end
      end

      FAULT: begin
        // q is ignored and prev_q / wrap_count stay frozen until cleared.
        if (clear) begin
          state_d      = IDLE;
          stall_cnt_d  = '0;
          locked_d     = 1'b0;
          fault_d      = 1'b0;
          fault_code_d = FC_NONE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (reset) begin
      state        <= IDLE;
      prev_q       <= '0;
      stall_cnt    <= '0;
      fault_code_r <= FC_NONE;
      locked       <= 1'b0;
      wrap_pulse   <= 1'b0;
      wrap_count   <= '0;
      step_error   <= 1'b0;
      fault        <= 1'b0;
    end else begin
      state        <= state_d;
      prev_q       <= prev_q_d;
      stall_cnt    <= stall_cnt_d;
      fault_code_r <= fault_code_d;
      locked       <= locked_d;
      wrap_pulse   <= wrap_pulse_d;
      wrap_count   <= wrap_count_d;
      step_error   <= step_error_d;
      fault        <= fault_d;
    end
  end

  assign fault_code = fault_code_r;

  // A wrap can only be flagged on a good step and step_error only on a bad
  // one, so the two pulses are mutually exclusive by construction.
  a_pulse_exclusive : assert property (@(posedge clk) disable iff (reset)
    !(wrap_pulse && step_error));

endmodule

// File: tb/tb_count_wrap_monitor.sv
// -----------------------------------------------------------------------------
// tb_count_wrap_monitor
//
// Drives two monitors from the same stimulus: one with the default 8-bit wrap
// counter and one with a 2-bit wrap counter, so saturation is exercised on the
// same traffic. Expected outputs come from a behavioural model that tracks the
// reference sample, the repeat count and the total number of wraps as plain
// integers. Directed steps come first, followed by a randomized run.
// -----------------------------------------------------------------------------
module tb_count_wrap_monitor;

  localparam int STALL_MAX = 2;

  logic       clk;
  logic       reset;
  logic       clear;
  logic [3:0] q;

  logic       locked,     locked2;
  logic       wrap_pulse, wrap_pulse2;
  logic [7:0] wrap_count;
  logic [1:0] wrap_count2;
  logic       step_error, step_error2;
  logic       fault,      fault2;
  logic [1:0] fault_code, fault_code2;

  count_wrap_monitor #(.WRAP_W(8), .STALL_MAX(STALL_MAX)) dut (
    .clk        (clk),
    .reset      (reset),
    .q          (q),
    .clear      (clear),
    .locked     (locked),
    .wrap_pulse (wrap_pulse),
    .wrap_count (wrap_count),
    .step_error (step_error),
    .fault      (fault),
    .fault_code (fault_code)
  );

  count_wrap_monitor #(.WRAP_W(2), .STALL_MAX(STALL_MAX)) dut2 (
    .clk        (clk),
    .reset      (reset),
    .q          (q),
    .clear      (clear),
    .locked     (locked2),
    .wrap_pulse (wrap_pulse2),
    .wrap_count (wrap_count2),
    .step_error (step_error2),
    .fault      (fault2),
    .fault_code (fault_code2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Scoreboard counters
  // ---------------------------------------------------------------------------
  int n_cmp  = 0;
  int n_fail = 0;

  // ---------------------------------------------------------------------------
  // Behavioural reference model
  // ---------------------------------------------------------------------------
  bit m_have_ref = 0;   // a reference sample has been taken since (re)start
  bit m_faulted  = 0;   // sticky fault is active
  int m_reps     = 0;   // consecutive repeats seen so far
  int m_last     = 0;   // last sample taken as reference
  int m_total    = 0;   // unbounded number of wraps since reset

  bit e_locked = 0;
  bit e_pulse  = 0;
  bit e_serr   = 0;
  bit e_fault  = 0;
  int e_code   = 0;

  function automatic int sat(input int total, input int width);
    int top;
    top = (1 << width) - 1;
    return (total > top) ? top : total;
  endfunction

  function automatic void raise_fault(input int code);
    m_faulted = 1;
    e_serr    = 1;
    e_fault   = 1;
    e_locked  = 0;
    e_code    = code;
  endfunction

  function automatic void model(input bit r, input bit c, input int qv);
    e_pulse = 0;
    e_serr  = 0;
    if (r) begin
      m_have_ref = 0; m_faulted = 0; m_reps = 0; m_last = 0; m_total = 0;
      e_locked = 0; e_fault = 0; e_code = 0;
    end else if (m_faulted) begin
      if (c) begin
        m_faulted = 0; m_have_ref = 0; m_reps = 0;
        e_locked = 0; e_fault = 0; e_code = 0;
      end
    end else if (!m_have_ref) begin
      m_have_ref = 1; m_last = qv; m_reps = 0;
      e_locked = 0;
    end else if (c) begin
      m_have_ref = 0; m_last = qv; m_reps = 0;
      e_locked = 0; e_fault = 0; e_code = 0;
    end else begin
      if (qv == (m_last + 1) % 16) begin
        e_locked = 1;
        m_reps   = 0;
        if (m_last == 15) begin
          e_pulse = 1;
          m_total++;
        end
      end else if (qv == m_last) begin
        if (m_reps == STALL_MAX) raise_fault(2);
        else m_reps++;
      end else begin
        raise_fault(1);
      end
      m_last = qv;
    end
  endfunction

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "/locked"},       32'(locked),      32'(e_locked));
    check({tag, "/wrap_pulse"},   32'(wrap_pulse),  32'(e_pulse));
    check({tag, "/wrap_count"},   32'(wrap_count),  32'(sat(m_total, 8)));
    check({tag, "/step_error"},   32'(step_error),  32'(e_serr));
    check({tag, "/fault"},        32'(fault),       32'(e_fault));
    check({tag, "/fault_code"},   32'(fault_code),  32'(e_code));
    check({tag, "/locked2"},      32'(locked2),     32'(e_locked));
    check({tag, "/wrap_pulse2"},  32'(wrap_pulse2), 32'(e_pulse));
    check({tag, "/wrap_count2"},  32'(wrap_count2), 32'(sat(m_total, 2)));
    check({tag, "/step_error2"},  32'(step_error2), 32'(e_serr));
    check({tag, "/fault2"},       32'(fault2),      32'(e_fault));
    check({tag, "/fault_code2"},  32'(fault_code2), 32'(e_code));
    check({tag, "/pulse_excl"},   32'(wrap_pulse & step_error), 32'd0);
  endtask

  logic [3:0] cur_q = 4'd0;

  // Apply one set of inputs away from the active edge, advance the model for
  // that edge, then compare just after the edge.
  task automatic step(input bit r, input bit c, input logic [3:0] qv, input string tag);
    @(negedge clk);
    reset = r;
    clear = c;
    q     = qv;
    model(r, c, int'(qv));
    @(posedge clk);
    #1;
    check_all(tag);
    cur_q = qv;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  int unsigned roll;

  initial begin
    reset = 1'b1;
    clear = 1'b0;
    q     = 4'd0;

    // Reset held across the first edges; reset must also beat clear.
    @(posedge clk);
    #1;
    check("reset_first_edge/locked", 32'(locked), 32'd0);
    check("reset_first_edge/fault",  32'(fault),  32'd0);
    step(1, 0, 4'd0, "reset");
    step(1, 1, 4'd9, "reset_vs_clear");

    // First edge after reset only captures; lock follows on the next good step.
    step(0, 0, 4'd0, "idle_capture");
    for (int i = 1; i <= 17; i++) step(0, 0, 4'(i), "count_up");
    check("first_wrap/wrap_count", 32'(wrap_count), 32'd1);

    // Jump 3 -> 7 while locked.
    step(0, 0, 4'd2, "pre_jump");
    step(0, 0, 4'd3, "pre_jump");
    step(0, 0, 4'd7, "jump");
    check("jump/fault_code", 32'(fault_code), 32'd1);
    for (int i = 0; i < 3; i++) step(0, 0, 4'($urandom), "fault_hold");

    // Clear out of FAULT, re-acquire, then tolerate two repeats.
    step(0, 1, 4'($urandom), "clear_fault");
    step(0, 0, 4'd4, "reacquire");
    step(0, 0, 4'd5, "relock");
    step(0, 0, 4'd5, "stall_rep1");
    step(0, 0, 4'd5, "stall_rep2");
    step(0, 0, 4'd6, "stall_recover");
    check("stall_recover/fault", 32'(fault), 32'd0);

    // Clear beats a jump in TRACK; clear in IDLE is just a capture.
    step(0, 1, 4'd3, "clear_over_jump");
    step(0, 1, 4'd4, "clear_in_idle");
    step(0, 0, 4'd5, "lock_again");
    step(0, 0, 4'd5, "stall_a");
    step(0, 0, 4'd5, "stall_b");
    step(0, 0, 4'd5, "stall_fault");
    check("stall_fault/fault_code", 32'(fault_code), 32'd2);

    // Reset while in FAULT, then five wraps to saturate the narrow counter.
    step(1, 1, 4'd0, "reset_in_fault");
    step(0, 0, 4'd0, "wrap_capture");
    for (int i = 1; i <= 80; i++) step(0, 0, 4'(i), "wraps");
    check("five_wraps/wrap_count",  32'(wrap_count),  32'd5);
    check("five_wraps/wrap_count2", 32'(wrap_count2), 32'd3);

    // Reset in the middle of tracking.
    step(0, 0, 4'd1, "pre_reset_track");
    step(1, 0, 4'd2, "reset_mid_track");
    step(0, 0, 4'd0, "after_reset");

    // Randomized traffic, mostly good steps with stalls, jumps, clears, resets.
    for (int n = 0; n < 400; n++) begin
      roll = $urandom_range(0, 99);
      if (roll < 68)      step(0, 0, cur_q + 4'd1, "rand_step");
      else if (roll < 84) step(0, 0, cur_q, "rand_stall");
      else if (roll < 90) step(0, 0, 4'($urandom), "rand_jump");
      else if (roll < 98) step(0, 1, cur_q + 4'd1, "rand_clear");
      else                step(1, 0, 4'($urandom), "rand_reset");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Guard against a stuck run.
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/count_wrap_monitor.md
COUNT_WRAP_MONITOR -- requirements
Module: count_wrap_monitor

Interface
REQ-001 Parameter: WRAP_W, default 8, width of the wrap counter.
REQ-002 Parameter: STALL_MAX, default 2, number of consecutive unchanged samples tolerated before a stall fault.
REQ-003 clk  input  1  sole clock; all state updates on posedge.
REQ-004 reset  input  1  synchronous, active-high reset; sampled on posedge clk.
REQ-005 q  input  4  count value from the upstream 4-bit ripple carry counter, sampled on posedge clk.
REQ-006 clear  input  1  synchronous fault/lock clear request.
REQ-007 locked  output  1  high while the monitor is tracking a valid +1 sequence.
REQ-008 wrap_pulse  output  1  one-cycle pulse on each detected 15->0 wrap.
REQ-009 wrap_count  output  WRAP_W  number of wraps seen, saturating.
REQ-010 step_error  output  1  one-cycle pulse on fault entry.
REQ-011 fault  output  1  sticky fault flag.
REQ-012 fault_code  output  2  00 none, 01 jump, 10 stall; 11 unused.

Function
REQ-013 The block SHALL implement a three-state FSM: IDLE, TRACK, FAULT; all outputs registered, one-cycle latency from the sampled q.
REQ-014 The block SHALL keep prev_q (4 bits) and stall_cnt (wide enough for STALL_MAX); prev_q <= q on every non-reset edge in IDLE and TRACK.
REQ-015 IDLE: capture q into prev_q, clear stall_cnt, go to TRACK; no checks; locked=0.
REQ-016 TRACK, q == prev_q+1 mod 16: stall_cnt <= 0, stay TRACK; locked=1.
REQ-017 TRACK, prev_q==15 and q==0: additionally wrap_pulse <= 1 for exactly one cycle and wrap_count <= wrap_count+1, saturating at all-ones (saturated wraps still pulse).
REQ-018 TRACK, q == prev_q: if stall_cnt == STALL_MAX go to FAULT with fault_code=10, else stall_cnt <= stall_cnt+1.
REQ-019 TRACK, any other q (jump): go to FAULT with fault_code=01.
REQ-020 FAULT entry: step_error=1 for exactly one cycle, fault=1, locked=0; fault and fault_code hold while in FAULT.
REQ-021 FAULT: wrap_count and prev_q frozen; q ignored.
REQ-022 clear=1 in TRACK or FAULT: next state IDLE, fault=0, fault_code=00, stall_cnt=0; wrap_count retained; clear has priority over TRACK checks.
REQ-023 clear=1 in IDLE: no effect beyond normal IDLE behaviour.
REQ-024 wrap_pulse and step_error SHALL never be high in the same cycle.

Reset
REQ-025 reset=1 at posedge SHALL force: state IDLE, prev_q=0, stall_cnt=0, locked=0, wrap_pulse=0, wrap_count=0, step_error=0, fault=0, fault_code=00.
REQ-026 reset SHALL dominate clear and all FSM transitions, including mid-TRACK and in FAULT.
REQ-027 After reset deasserts, first posedge is the IDLE capture; locked rises after the second posedge with a valid +1 step.

Verification
REQ-028 10 ns clk, reset=1 for 15 ns -> all outputs 0, locked=0 during reset.
REQ-029 After reset, q = 0,1,...,15,0,1 one per cycle -> locked=1 from first checked edge; single wrap_pulse at the 15->0 sample; wrap_count=1; fault=0.
REQ-030 While locked, q steps 3->7 -> step_error pulses one cycle, fault=1, fault_code=01, locked=0, wrap_count unchanged.
REQ-031 STALL_MAX=2, q held at 5 for 3 repeated samples -> fault on third repeated sample, fault_code=10; two repeats then 6 -> no fault.
REQ-032 In FAULT, clear=1 one cycle -> fault=0, fault_code=00, IDLE, wrap_count retained; resume counting -> locked=1 again.
REQ-033 WRAP_W=2, 5 wraps -> wrap_count saturates at 3, wrap_pulse on all 5; reset mid-TRACK -> all outputs 0 next edge.
